intsrc_gate: RTL and testbench

- Sits directly upstream of the interrupt controller's source side.
- Converts raw peripheral interrupt lines into the controller's request/ready handshake, one channel per controller source index:
  - synchronises each line;
  - applies polarity;
  - detects edges or follows levels;
  - latches pending edges while the controller is servicing.
- Software configures and inspects it through a small pi1 register window.

---
 rtl/intsrc_pkg.sv | 30 +++
 rtl/intsrc_chan.sv | 111 +++++++++++
 rtl/intsrc_gate.sv | 107 ++++++++++
 tb/tb_intsrc_gate.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intsrc_pkg.sv
// intsrc_pkg: shared definitions for the interrupt source gate.
package intsrc_pkg;

    typedef enum logic [1:0] {
        PINOOP = 2'b00,
        PIWROP = 2'b01,
        PIRDOP = 2'b10,
        PIRWOP = 2'b11
    } pi1_op_e;

    localparam logic [1:0] REGMODE = 2'd0;
    localparam logic [1:0] REGPOL  = 2'd1;
    localparam logic [1:0] REGPEND = 2'd2;
    localparam logic [1:0] REGOVF  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } chan_state_e;

    function automatic logic op_writes(input logic [1:0] op);
        return (op == PIWROP) || (op == PIRWOP);
    endfunction

    function automatic logic op_reads(input logic [1:0] op);
        return (op == PIRDOP) || (op == PIRWOP);
    endfunction

endpackage

// File: rtl/intsrc_chan.sv
// intsrc_chan: one interrupt channel - synchroniser, polarity, edge
// detect, pending/overflow bits and the request/ready handshake FSM.
//
//   state | meaning
//   IDLE  | no request presented to the controller
//   REQ   | intrqst_o high, waiting for the controller to take it
//   SERV  | controller is servicing (intrdy_i low), waiting for release
module intsrc_chan
    import intsrc_pkg::*;
#(
    parameter int SYNCSTAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    input  logic mode_i,
    input  logic pol_i,
    input  logic pol_nxt_i,
    input  logic cfg_wr_i,
    input  logic pend_clr_i,
    input  logic ovf_clr_i,
    input  logic intrdy_i,
    output logic intrqst_o,
    output logic pend_o,
    output logic ovf_o
);

    logic [SYNCSTAGES-1:0] sync_q;
    logic                  prev_q;
    logic                  pend_q;
    logic                  ovf_q;
    logic                  rqst_q;
    chan_state_e           state_q;

    logic s_w;
    logic rise_w;
    logic set_w;
    logic accept_w;
    logic lvl_w;
    logic pend_d;
    logic ovf_d;

    assign s_w      = sync_q[SYNCSTAGES-1] ^ pol_i;
    // A MODE/POL write reloads prev with the new view of the line, so the
    // flip itself never looks like a rising edge.
    assign rise_w   = s_w & ~prev_q & ~cfg_wr_i;
    assign set_w    = rise_w & mode_i;
    assign accept_w = (state_q == REQ) & ~intrdy_i;
    // Level mode follows the registered line so both modes share one latency.
    assign lvl_w    = prev_q;

    // A fresh edge always wins over a software or acceptance clear.
    assign pend_d = set_w | (pend_q & ~pend_clr_i & ~(accept_w & mode_i));
    // An edge coinciding with acceptance refills PEND without overflowing.
    assign ovf_d  = (set_w & pend_q & ~accept_w) | (ovf_q & ~ovf_clr_i);

    // Synchroniser, line history and pending/overflow bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNCSTAGES-2:0], irq_i};
            prev_q <= sync_q[SYNCSTAGES-1] ^ pol_nxt_i;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    // Handshake FSM with registered request output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rqst_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mode_i ? pend_q : lvl_w) begin
                        state_q <= REQ;
                        rqst_q  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!intrdy_i) begin
                        state_q <= SERV;
                        rqst_q  <= 1'b0;
                    end else if (mode_i ? !pend_q : !lvl_w) begin
                        state_q <= IDLE;
                        rqst_q  <= 1'b0;
                    end
                end
                SERV: begin
                    if (intrdy_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rqst_q  <= 1'b0;
                end
            endcase
        end
    end

    assign intrqst_o = rqst_q;
    assign pend_o    = pend_q;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/intsrc_gate.sv
// intsrc_gate: converts raw peripheral interrupt lines into the interrupt
// controller's request/ready handshake, with a four-word pi1 register window.
module intsrc_gate
    import intsrc_pkg::*;
#(
    parameter int  NCHAN      = 8,
    parameter int  ARCHBITSZ  = 32,
    parameter int  SYNCSTAGES = 2,
    localparam int ADDRBITSZ  = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    output logic [ADDRBITSZ-1:0]   pi1_mapsz_o,
    input  logic [NCHAN-1:0]       irq_i,
    output logic [NCHAN-1:0]       intrqst_o,
    input  logic [NCHAN-1:0]       intrdy_i
);

    logic [NCHAN-1:0]     mode_q;
    logic [NCHAN-1:0]     pol_q;
    logic [ARCHBITSZ-1:0] rdat_q;
    logic [ARCHBITSZ-1:0] rdat_d;

    logic             wr_w;
    logic             rd_w;
    logic [1:0]       reg_w;
    logic [NCHAN-1:0] wdat_w;
    logic             mode_wr_w;
    logic             pol_wr_w;
    logic             cfg_wr_w;
    logic [NCHAN-1:0] pol_nxt_w;
    logic [NCHAN-1:0] pend_clr_w;
    logic [NCHAN-1:0] ovf_clr_w;
    logic [NCHAN-1:0] pend_w;
    logic [NCHAN-1:0] ovf_w;
    logic             unused_w;

    // Byte enables and upper address bits carry no meaning here.
    assign unused_w = ^{pi1_sel_i, pi1_addr_i, pi1_data_i};

    assign wr_w       = op_writes(pi1_op_i);
    assign rd_w       = op_reads(pi1_op_i);
    assign reg_w      = pi1_addr_i[1:0];
    assign wdat_w     = pi1_data_i[NCHAN-1:0];
    assign mode_wr_w  = wr_w && (reg_w == REGMODE);
    assign pol_wr_w   = wr_w && (reg_w == REGPOL);
    assign cfg_wr_w   = mode_wr_w || pol_wr_w;
    assign pol_nxt_w  = pol_wr_w ? wdat_w : pol_q;
    assign pend_clr_w = (wr_w && (reg_w == REGPEND)) ? wdat_w : '0;
    assign ovf_clr_w  = (wr_w && (reg_w == REGOVF)) ? wdat_w : '0;

    assign pi1_rdy_o   = 1'b1;
    assign pi1_mapsz_o = ADDRBITSZ'(4);

    // Read mux over the current (pre-write) register values.
    always_comb begin
        rdat_d = '0;
        case (reg_w)
            REGMODE: rdat_d[NCHAN-1:0] = mode_q;
            REGPOL:  rdat_d[NCHAN-1:0] = pol_q;
            REGPEND: rdat_d[NCHAN-1:0] = pend_w;
            default: rdat_d[NCHAN-1:0] = ovf_w;
        endcase
    end

    // Configuration registers and registered read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= '0;
            pol_q  <= '0;
            rdat_q <= '0;
        end else begin
            if (mode_wr_w) mode_q <= wdat_w;
            if (pol_wr_w)  pol_q  <= wdat_w;
            if (rd_w)      rdat_q <= rdat_d;
        end
    end

    assign pi1_data_o = rdat_q;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        intsrc_chan #(
            .SYNCSTAGES(SYNCSTAGES)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .irq_i     (irq_i[i]),
            .mode_i    (mode_q[i]),
            .pol_i     (pol_q[i]),
            .pol_nxt_i (pol_nxt_w[i]),
            .cfg_wr_i  (cfg_wr_w),
            .pend_clr_i(pend_clr_w[i]),
            .ovf_clr_i (ovf_clr_w[i]),
            .intrdy_i  (intrdy_i[i]),
            .intrqst_o (intrqst_o[i]),
            .pend_o    (pend_w[i]),
            .ovf_o     (ovf_w[i])
        );
    end

endmodule

// File: tb/tb_intsrc_gate.sv
// tb_intsrc_gate: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the channel rules.
module tb_intsrc_gate;

    localparam int N    = 8;
    localparam int W    = 32;
    localparam int AW   = 30;
    localparam int SYNC = 2;

    logic          clk;
    logic          rst;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic [W/8-1:0] sel;
    logic          rdy;
    logic [AW-1:0] mapsz;
    logic [N-1:0]  irq;
    logic [N-1:0]  rqst;
    logic [N-1:0]  intrdy;

    intsrc_gate #(.NCHAN(N), .ARCHBITSZ(W), .SYNCSTAGES(SYNC)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pi1_op_i   (op),
        .pi1_addr_i (addr),
        .pi1_data_i (wdata),
        .pi1_data_o (rdata),
        .pi1_sel_i  (sel),
        .pi1_rdy_o  (rdy),
        .pi1_mapsz_o(mapsz),
        .irq_i      (irq),
        .intrqst_o  (rqst),
        .intrdy_i   (intrdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Channel phases: 0 quiet, 1 requesting, 2 being serviced.
    logic [N-1:0] hist[$];      // past irq samples, newest first
    logic [N-1:0] m_mode, m_pol, m_prev, m_pend, m_ovf;
    int           m_ph[N];
    logic [W-1:0] m_rdata;

    function automatic logic [N-1:0] m_rqst();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_ph[i] == 1);
        return v;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SYNC; k++) hist.push_back('0);
        m_mode = '0; m_pol = '0; m_prev = '0; m_pend = '0; m_ovf = '0;
        m_rdata = '0;
        for (int i = 0; i < N; i++) m_ph[i] = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        logic [N-1:0] line, act, rise, npol, nmode, pclr, oclr, npend, novf;
        logic [W-1:0] rv;
        bit wr, rd, acc, want, drop;
        int a;
        line = hist[SYNC-1];
        act  = line ^ m_pol;
        wr   = (op == 2'b01) || (op == 2'b11);
        rd   = (op == 2'b10) || (op == 2'b11);
        a    = int'(addr[1:0]);
        npol = m_pol; nmode = m_mode; pclr = '0; oclr = '0;
        if (wr) begin
            case (a)
                0: nmode = wdata[N-1:0];
                1: npol  = wdata[N-1:0];
                2: pclr  = wdata[N-1:0];
                default: oclr = wdata[N-1:0];
            endcase
        end
        if (rd) begin
            rv = '0;
            case (a)
                0: rv[N-1:0] = m_mode;
                1: rv[N-1:0] = m_pol;
                2: rv[N-1:0] = m_pend;
                default: rv[N-1:0] = m_ovf;
            endcase
            m_rdata = rv;
        end
        rise = (wr && a < 2) ? '0 : (act & ~m_prev);
        npend = m_pend; novf = m_ovf;
        for (int i = 0; i < N; i++) begin
            acc  = 0;
            want = m_mode[i] ? m_pend[i] : m_prev[i];
            drop = !want;
            if (m_ph[i] == 0) begin
                if (want) m_ph[i] = 1;
            end else if (m_ph[i] == 1) begin
                if (!intrdy[i]) begin
                    m_ph[i] = 2;
                    acc = 1;
                end else if (drop) begin
                    m_ph[i] = 0;
                end
            end else begin
                if (intrdy[i]) m_ph[i] = 0;
            end
            if (m_mode[i] && rise[i]) npend[i] = 1'b1;
            else if (pclr[i] || (acc && m_mode[i])) npend[i] = 1'b0;
            if (m_mode[i] && rise[i] && m_pend[i] && !acc) novf[i] = 1'b1;
            else if (oclr[i]) novf[i] = 1'b0;
        end
        m_pend = npend;
        m_ovf  = novf;
        m_prev = line ^ npol;
        m_pol  = npol;
        m_mode = nmode;
        hist.push_front(irq);
        void'(hist.pop_back());
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check("rqst", W'(rqst), W'(m_rqst()));
        check("rdata", rdata, m_rdata);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus(input logic [1:0] o, input int a, input logic [W-1:0] d);
        op = o; addr = AW'(a); wdata = d;
        tick();
        op = 2'b00;
    endtask

    task automatic rd_check(input string tag, input int a, input logic [W-1:0] exp);
        bus(2'b10, a, '0);
        check(tag, rdata, exp);
    endtask

    task automatic pulse(input int ch);
        irq[ch] = 1'b1;
        tick();
        irq[ch] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op = '0; addr = '0; wdata = '0; sel = '1;
        irq = '0; intrdy = '1;
        model_reset();
        #2;
        check("reset_rqst", W'(rqst), '0);
        check("reset_rdata", rdata, '0);
        check("mapsz", W'(mapsz), 32'd4);
        check("pi1_rdy", W'(rdy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Edge mode, single pulse on channel 0
        bus(2'b01, 0, 32'h01);
        ticks(2);
        irq[0] = 1'b1;
        tick();                                    // cycle 1
        irq[0] = 1'b0;
        ticks(2);                                  // cycle 3
        check("edge_lat_c3", W'(rqst[0]), 32'd0);
        tick();                                    // cycle 4
        check("edge_lat_c4", W'(rqst[0]), 32'd1);
        ticks(2);                                  // cycle 6
        intrdy[0] = 1'b0;
        tick();                                    // cycle 7
        check("accept_drop", W'(rqst[0]), 32'd0);
        rd_check("pend_after_accept", 2, 32'h0);
        intrdy[0] = 1'b1;
        ticks(4);
        check("idle_after_release", W'(rqst[0]), 32'd0);

        // Edges while the controller is servicing channel 0
        pulse(0);
        ticks(3);
        intrdy[0] = 1'b0;
        tick();
        pulse(0);
        ticks(4);
        rd_check("serv_pend", 2, 32'h01);
        rd_check("serv_ovf0", 3, 32'h00);
        pulse(0);
        ticks(4);
        rd_check("serv_ovf1", 3, 32'h01);
        intrdy[0] = 1'b1;
        ticks(2);
        check("rerequest", W'(rqst[0]), 32'd1);
        bus(2'b01, 3, 32'h01);
        rd_check("ovf_cleared", 3, 32'h00);
        intrdy[0] = 1'b0;
        tick();
        intrdy[0] = 1'b1;
        ticks(3);

        // Level mode with withdrawal on channel 3
        bus(2'b01, 0, 32'h00);
        ticks(2);
        irq[3] = 1'b1;
        ticks(3);
        check("lvl_lat_c3", W'(rqst[3]), 32'd0);
        tick();
        check("lvl_lat_c4", W'(rqst[3]), 32'd1);
        irq[3] = 1'b0;
        ticks(3);
        check("lvl_hold", W'(rqst[3]), 32'd1);
        tick();
        check("lvl_withdraw", W'(rqst[3]), 32'd0);
        ticks(6);
        check("lvl_quiet", W'(rqst[3]), 32'd0);

        // Polarity flip on channel 2, then mode flip without a spurious edge
        bus(2'b01, 1, 32'h04);
        ticks(3);
        check("pol_request", W'(rqst[2]), 32'd1);
        bus(2'b01, 0, 32'h04);
        tick();
        rd_check("pol_no_edge", 2, 32'h0);
        bus(2'b01, 1, 32'h00);
        bus(2'b01, 0, 32'h00);
        ticks(3);

        // Register access
        bus(2'b11, 0, 32'h123456A5);
        check("rw_old", rdata, 32'h0);
        rd_check("rw_new", 0, 32'h000000A5);
        bus(2'b01, 0, 32'h0);
        bus(2'b01, 3, 32'hFF);
        rd_check("ovf_w1c_noop", 3, 32'h0);
        bus(2'b01, 2, 32'hFF);
        ticks(2);

        // Asynchronous reset in the middle of a service
        bus(2'b01, 0, 32'h01);
        irq[1] = 1'b1;
        pulse(0);
        ticks(3);
        intrdy[0] = 1'b0;
        tick();
        rd_check("mode_before_rst", 0, 32'h01);
        #2;
        rst = 1'b1;
        #1;
        check("async_rqst", W'(rqst), '0);
        check("async_rdata", rdata, '0);
        @(posedge clk);
        #1;
        check("rst_hold_rqst", W'(rqst), '0);
        intrdy = '1;
        rst = 1'b0;
        model_reset();
        ticks(3);
        check("post_rst_c3", W'(rqst[1]), 32'd0);
        tick();
        check("post_rst_c4", W'(rqst[1]), 32'd1);
        rd_check("mode_after_rst", 0, 32'h0);
        irq[1] = 1'b0;
        ticks(5);

        // Randomized traffic
        for (int c = 0; c < 5000; c++) begin
            int r;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) irq[i] = ~irq[i];
                if ($urandom_range(0, 7) == 0) intrdy[i] = ~intrdy[i];
            end
            r = $urandom_range(0, 15);
            if (r < 9)       op = 2'b00;
            else if (r < 12) op = 2'b10;
            else if (r < 14) op = 2'b01;
            else             op = 2'b11;
            addr  = AW'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 1) == 0) wdata[N-1:0] = N'($urandom_range(0, 3));
            sel   = (W/8)'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
